rf_alu_sequencer: RTL and testbench

- Multi-cycle controller that executes single register-to-register commands on the team's 8x8 register file and add/sub ALU.
- Accepts one command per valid/ready handshake, then sequences the following, each in its own state:
  - register-file reads
  - ALU execution
  - register-file write-back
- Sits in the top level between switch/key input decoding and the existing RegisterFile and ULA instances.
- Those instances stay outside this block.

---
 rtl/rf_seq_pkg.sv | 23 ++
 rtl/rf_alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared opcode/state encodings and default widths for the register-file/ALU sequencer.
package rf_seq_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_MOV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle controller: accepts one register-to-register command, then reads the
// register file, runs the external add/sub ALU and writes the result back.
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_wa3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_ovf,
    output logic              done,
    output logic              last_ovf,
    output logic [CNT_W-1:0]  op_count
);

    state_e            state;
    state_e            state_next;
    logic              accept_c;

    op_e               op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;
    logic              sel_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; LOADI skips straight to write-back, MOV skips the ALU
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept_c   = 1'b1;
                    state_next = (op_e'(cmd_op) == OP_LOADI) ? S_WB : S_READ;
                end
            end
            S_READ:  state_next = (op_q == OP_MOV) ? S_WB : S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch and operand/result pipeline; LOADI parks its immediate in result_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_LOADI;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        op_q     <= op_e'(cmd_op);
                        dst_q    <= cmd_dst;
                        src1_q   <= cmd_src1;
                        src2_q   <= cmd_src2;
                        result_q <= cmd_imm;
                        ovf_q    <= 1'b0;
                        sel_q    <= (op_e'(cmd_op) == OP_SUB);
                    end
                end
                S_READ: begin
                    opa_q <= rf_rd1;
                    opb_q <= rf_rd2;
                    if (op_q == OP_MOV) begin
                        result_q <= rf_rd1;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_s;
                    ovf_q    <= alu_ovf;
                end
                default: ;
            endcase
        end
    end

    // Registered handshake/strobe outputs and completion bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            rf_we3    <= 1'b0;
            done      <= 1'b0;
            last_ovf  <= 1'b0;
            op_count  <= '0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);
            rf_we3    <= (state_next == S_WB);
            done      <= (state_next == S_DONE);
            if (state == S_WB) begin
                op_count <= op_count + CNT_W'(1);
                last_ovf <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf_q : 1'b0;
            end
        end
    end

    // Address/operand outputs follow the latched command fields directly
    assign rf_ra1  = src1_q;
    assign rf_ra2  = src2_q;
    assign rf_wa3  = dst_q;
    assign rf_wd3  = result_q;
    assign alu_a   = opa_q;
    assign alu_b   = opb_q;
    assign alu_sel = sel_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Self-checking bench: stand-in register file and ALU around the sequencer, checked
// against a command-level reference model.
module tb_rf_alu_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] C_LOADI = 2'b00;
    localparam logic [1:0] C_ADD   = 2'b01;
    localparam logic [1:0] C_SUB   = 2'b10;
    localparam logic [1:0] C_MOV   = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] rf_ra1;
    logic [ADDR_W-1:0] rf_ra2;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              rf_we3;
    logic [ADDR_W-1:0] rf_wa3;
    logic [DATA_W-1:0] rf_wd3;
    logic              alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_s;
    logic              alu_ovf;
    logic              done;
    logic              last_ovf;
    logic [CNT_W-1:0]  op_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_accept = 0;
    int n_we     = 0;

    logic [DATA_W-1:0] rf_hw  [8];
    logic [DATA_W-1:0] ref_rf [8];
    logic [CNT_W-1:0]  ref_cnt;
    logic              ref_ovf;

    rf_alu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_ovf(alu_ovf),
        .done(done), .last_ovf(last_ovf), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in register file: combinational reads, write on rising edge
    assign rf_rd1 = rf_hw[rf_ra1];
    assign rf_rd2 = rf_hw[rf_ra2];
    always @(posedge clk) begin
        if (rf_we3) begin
            rf_hw[rf_wa3] <= rf_wd3;
        end
    end

    // Stand-in ALU with signed overflow
    assign alu_s   = alu_sel ? 8'(alu_a - alu_b) : 8'(alu_a + alu_b);
    assign alu_ovf = alu_sel ? ((alu_a[7] != alu_b[7]) && (alu_s[7] != alu_a[7]))
                             : ((alu_a[7] == alu_b[7]) && (alu_s[7] != alu_a[7]));

    // Handshake and write-pulse counters
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) n_accept++;
        if (rf_we3) n_we++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_we3"},   32'(rf_we3), 32'd0);
        check({tag, "_ovf"},   32'(last_ovf), 32'd0);
        check({tag, "_cnt"},   32'(op_count), 32'd0);
        check({tag, "_ra1"},   32'(rf_ra1), 32'd0);
        check({tag, "_alua"},  32'(alu_a), 32'd0);
        check({tag, "_wd3"},   32'(rf_wd3), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        ref_cnt = '0;
        ref_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Issue one command and check every cycle up to and including done
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [7:0] imm, input bit keep_valid);
        logic [7:0] a, b, res;
        logic       ovf;
        int         lat, r;
        a = ref_rf[s1];
        b = ref_rf[s2];
        ovf = 1'b0;
        case (op)
            C_LOADI: begin res = imm; lat = 2; end
            C_ADD: begin
                r = int'($signed(a)) + int'($signed(b));
                res = 8'(r); ovf = (r > 127) || (r < -128); lat = 4;
            end
            C_SUB: begin
                r = int'($signed(a)) - int'($signed(b));
                res = 8'(r); ovf = (r > 127) || (r < -128); lat = 4;
            end
            default: begin res = a; lat = 3; end
        endcase
        cmd_op = op; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8 && !cmd_ready; i++) @(negedge clk);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            cmd_valid = 1'b0;
            cmd_op = 2'($urandom); cmd_dst = 3'($urandom); cmd_src1 = 3'($urandom);
            cmd_src2 = 3'($urandom); cmd_imm = 8'($urandom);
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("we3", 32'(rf_we3), 32'(c == lat - 1));
            check("done", 32'(done), 32'(c == lat));
            check("ready_busy", 32'(cmd_ready), 32'd0);
            if (c == lat - 1) begin
                check("wa3", 32'(rf_wa3), 32'(d));
                check("wd3", 32'(rf_wd3), 32'(res));
            end
            if ((op == C_ADD || op == C_SUB) && c == 2) begin
                check("alu_sel", 32'(alu_sel), 32'(op == C_SUB));
                check("alu_a", 32'(alu_a), 32'(a));
                check("alu_b", 32'(alu_b), 32'(b));
            end
        end
        ref_rf[d] = res;
        ref_cnt = ref_cnt + 8'd1;
        ref_ovf = ovf;
        check("last_ovf", 32'(last_ovf), 32'(ref_ovf));
        check("op_count", 32'(op_count), 32'(ref_cnt));
        check("rf_value", 32'(rf_hw[d]), 32'(res));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int acc0, we0;
        logic [7:0] r7_before;
        for (int i = 0; i < 8; i++) begin
            rf_hw[i]  = '0;
            ref_rf[i] = '0;
        end
        ref_cnt = '0;
        ref_ovf = 1'b0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Directed arithmetic sequence
        run_cmd(C_LOADI, 3'd3, 3'd0, 3'd0, 8'h5A, 1'b0);
        check("r3", 32'(rf_hw[3]), 32'h5A);
        run_cmd(C_LOADI, 3'd1, 3'd0, 3'd0, 8'h70, 1'b0);
        run_cmd(C_LOADI, 3'd2, 3'd0, 3'd0, 8'h20, 1'b0);
        run_cmd(C_ADD, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0);
        check("r4", 32'(rf_hw[4]), 32'h90);
        check("add_ovf", 32'(last_ovf), 32'd1);
        run_cmd(C_SUB, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0);
        check("r5", 32'(rf_hw[5]), 32'h50);
        check("sub_ovf", 32'(last_ovf), 32'd0);
        run_cmd(C_MOV, 3'd6, 3'd5, 3'd0, 8'h00, 1'b0);
        check("r6", 32'(rf_hw[6]), 32'h50);

        // Reset during EXEC of an ADD: abandoned with no write-back
        r7_before = rf_hw[7];
        cmd_op = C_ADD; cmd_dst = 3'd7; cmd_src1 = 3'd1; cmd_src2 = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        we0 = n_we;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_cnt = '0;
        ref_ovf = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_we", 32'(n_we - we0), 32'd0);
        check("mid_rst_r7", 32'(rf_hw[7]), 32'(r7_before));
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);

        // Valid held high across three back-to-back commands
        acc0 = n_accept;
        run_cmd(C_LOADI, 3'd0, 3'd0, 3'd0, 8'h11, 1'b1);
        run_cmd(C_ADD, 3'd7, 3'd0, 3'd0, 8'h00, 1'b1);
        run_cmd(C_MOV, 3'd3, 3'd7, 3'd0, 8'h00, 1'b1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("queued_accepts", 32'(n_accept - acc0), 32'd3);
        check("queued_count", 32'(op_count), 32'd3);
        check("queued_r3", 32'(rf_hw[3]), 32'h22);

        // Counter wrap after 256 completions
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_cmd(C_LOADI, 3'($urandom), 3'd0, 3'd0, 8'($urandom), 1'b0);
        end
        check("wrap_count", 32'(op_count), 32'd0);

        // Same-register sources and destination
        run_cmd(C_LOADI, 3'd1, 3'd0, 3'd0, 8'h01, 1'b0);
        run_cmd(C_ADD, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0);
        check("r1_dbl", 32'(rf_hw[1]), 32'h02);
        run_cmd(C_ADD, 3'd2, 3'd1, 3'd1, 8'h00, 1'b0);
        check("r2_dbl", 32'(rf_hw[2]), 32'h04);

        // Random mix
        for (int i = 0; i < 120; i++) begin
            run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            check("final_rf", 32'(rf_hw[i]), 32'(ref_rf[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
